// File: rtl/dispatch_rob_alloc.sv
// Dispatch stage between rename and the ROB/issue queues.
// Holds one renamed group per cycle, trims lanes behind the first exception,
// hands out densely packed ROB IDs and stalls on ROB room or IQ backpressure.
module dispatch_rob_alloc #(
    parameter int unsigned DISP_W    = 4,
    parameter int unsigned ROB_DEPTH = 64,
    parameter int unsigned IQ_NUM    = 4,
    parameter int unsigned PR_NUM    = 65,
    parameter int unsigned COMMIT_W  = 4,
    localparam int unsigned ROB_AW   = $clog2(ROB_DEPTH),
    localparam int unsigned PR_W     = $clog2(PR_NUM),
    localparam int unsigned CMT_W    = $clog2(COMMIT_W + 1),
    localparam int unsigned NUM_W    = $clog2(DISP_W + 1),
    localparam int unsigned PTR_W    = ROB_AW + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [PTR_W-1:0]           flush_rob_ptr,
    input  logic [CMT_W-1:0]           commit_num,
    input  logic [IQ_NUM-1:0]          iq_pause,
    input  logic [PR_NUM-1:0]          PR_status,
    input  logic [PR_NUM-1:0]          PR_wakeup,
    input  logic [DISP_W-1:0]          in_vld,
    input  logic [3*DISP_W-1:0]        in_except,
    input  logic [IQ_NUM*DISP_W-1:0]   in_iq_choose,
    input  logic [DISP_W-1:0]          in_src1_en,
    input  logic [DISP_W-1:0]          in_src2_en,
    input  logic [PR_W*DISP_W-1:0]     in_src1_pr,
    input  logic [PR_W*DISP_W-1:0]     in_src2_pr,
    output logic                       wr_pause,
    output logic                       disp_fire,
    output logic [PTR_W*DISP_W-1:0]    rob_id,
    output logic [DISP_W-1:0]          rob_wr_en,
    output logic [IQ_NUM*DISP_W-1:0]   iq_choose,
    output logic [DISP_W-1:0]          src1_rdy,
    output logic [DISP_W-1:0]          src2_rdy,
    output logic [NUM_W-1:0]           wr_rob_num,
    output logic [PTR_W-1:0]           rob_room
);

    logic [DISP_W-1:0]        g_vld;
    logic [3*DISP_W-1:0]      g_except;
    logic [IQ_NUM*DISP_W-1:0] g_iq;
    logic [DISP_W-1:0]        g_s1_en;
    logic [DISP_W-1:0]        g_s2_en;
    logic [PR_W*DISP_W-1:0]   g_s1_pr;
    logic [PR_W*DISP_W-1:0]   g_s2_pr;

    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         occ;

    logic                     nonempty;
    logic                     seen_exc;
    logic                     lane_exc;
    logic [NUM_W-1:0]         alloc_cnt;
    logic [IQ_NUM-1:0]        iq_used;
    logic [PR_W-1:0]          pr1;
    logic [PR_W-1:0]          pr2;

    // Group register: cleared on flush, loaded when not stalled, else held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_vld    <= '0;
            g_except <= '0;
            g_iq     <= '0;
            g_s1_en  <= '0;
            g_s2_en  <= '0;
            g_s1_pr  <= '0;
            g_s2_pr  <= '0;
        end else if (flush) begin
            g_vld    <= '0;
            g_except <= '0;
            g_iq     <= '0;
            g_s1_en  <= '0;
            g_s2_en  <= '0;
            g_s1_pr  <= '0;
            g_s2_pr  <= '0;
        end else if (!wr_pause) begin
            g_vld    <= in_vld;
            g_except <= in_except;
            g_iq     <= in_iq_choose;
            g_s1_en  <= in_src1_en;
            g_s2_en  <= in_src2_en;
            g_s1_pr  <= in_src1_pr;
            g_s2_pr  <= in_src2_pr;
        end
    end

    // Lane trimming, packed ROB ID assignment and IQ target filtering
    always_comb begin
        nonempty  = 1'b0;
        seen_exc  = 1'b0;
        lane_exc  = 1'b0;
        alloc_cnt = '0;
        iq_used   = '0;
        rob_wr_en = '0;
        iq_choose = '0;
        rob_id    = '0;
        for (int unsigned i = 0; i < DISP_W; i++) begin
            lane_exc = |g_except[3*i +: 3];
            nonempty = nonempty | g_vld[i] | lane_exc;
            rob_id[PTR_W*i +: PTR_W] = wr_ptr + PTR_W'(alloc_cnt);
            // the excepting lane still takes a ROB slot; everything behind it is dropped
            if ((g_vld[i] | lane_exc) && !seen_exc) begin
                rob_wr_en[i] = 1'b1;
                alloc_cnt    = alloc_cnt + 1'b1;
            end
            if (g_vld[i] && !lane_exc && !seen_exc) begin
                iq_choose[IQ_NUM*i +: IQ_NUM] = g_iq[IQ_NUM*i +: IQ_NUM];
                iq_used = iq_used | g_iq[IQ_NUM*i +: IQ_NUM];
            end
            seen_exc = seen_exc | lane_exc;
        end
    end

    assign wr_rob_num = alloc_cnt;
    assign rob_room   = PTR_W'(ROB_DEPTH) - occ;
    assign wr_pause   = nonempty &
                        ((32'(alloc_cnt) > 32'(rob_room)) | (|(iq_used & iq_pause)));
    assign disp_fire  = nonempty & ~wr_pause & ~flush;

    // Source readiness with same-cycle wakeup; out-of-range registers read as ready
    always_comb begin
        src1_rdy = '1;
        src2_rdy = '1;
        pr1      = '0;
        pr2      = '0;
        for (int unsigned i = 0; i < DISP_W; i++) begin
            pr1 = g_s1_pr[PR_W*i +: PR_W];
            pr2 = g_s2_pr[PR_W*i +: PR_W];
            if (g_s1_en[i] && (32'(pr1) < PR_NUM))
                src1_rdy[i] = PR_status[pr1] | PR_wakeup[pr1];
            if (g_s2_en[i] && (32'(pr2) < PR_NUM))
                src2_rdy[i] = PR_status[pr2] | PR_wakeup[pr2];
        end
    end

    // Write pointer and occupancy; flush overrides dispatch and commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= flush_rob_ptr;
            occ    <= '0;
        end else begin
            if (disp_fire)
                wr_ptr <= wr_ptr + PTR_W'(alloc_cnt);
            occ <= occ + (disp_fire ? PTR_W'(alloc_cnt) : PTR_W'(0)) - PTR_W'(commit_num);
        end
    end

endmodule

// File: tb/tb_dispatch_rob_alloc.sv
// Directed bench for dispatch_rob_alloc: allocation, wrap, exception trim,
// IQ pause, ROB-full stall, flush recovery and source-ready bypass.
module tb_dispatch_rob_alloc;

    localparam int unsigned DISP_W = 4;
    localparam int unsigned IQ_NUM = 4;
    localparam int unsigned PR_NUM = 65;
    localparam int unsigned PR_W   = 7;
    localparam int unsigned PTR_W  = 7;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     flush = 1'b0;
    logic [PTR_W-1:0]         flush_rob_ptr = '0;
    logic [2:0]               commit_num = '0;
    logic [IQ_NUM-1:0]        iq_pause = '0;
    logic [PR_NUM-1:0]        PR_status = '0;
    logic [PR_NUM-1:0]        PR_wakeup = '0;
    logic [DISP_W-1:0]        in_vld = '0;
    logic [3*DISP_W-1:0]      in_except = '0;
    logic [IQ_NUM*DISP_W-1:0] in_iq_choose = '0;
    logic [DISP_W-1:0]        in_src1_en = '0;
    logic [DISP_W-1:0]        in_src2_en = '0;
    logic [PR_W*DISP_W-1:0]   in_src1_pr = '0;
    logic [PR_W*DISP_W-1:0]   in_src2_pr = '0;

    logic                     wr_pause;
    logic                     disp_fire;
    logic [PTR_W*DISP_W-1:0]  rob_id;
    logic [DISP_W-1:0]        rob_wr_en;
    logic [IQ_NUM*DISP_W-1:0] iq_choose;
    logic [DISP_W-1:0]        src1_rdy;
    logic [DISP_W-1:0]        src2_rdy;
    logic [2:0]               wr_rob_num;
    logic [PTR_W-1:0]         rob_room;

    int n_cmp = 0;
    int n_bad = 0;

    dispatch_rob_alloc #(
        .DISP_W    (4),
        .ROB_DEPTH (64),
        .IQ_NUM    (4),
        .PR_NUM    (65),
        .COMMIT_W  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .flush_rob_ptr (flush_rob_ptr),
        .commit_num    (commit_num),
        .iq_pause      (iq_pause),
        .PR_status     (PR_status),
        .PR_wakeup     (PR_wakeup),
        .in_vld        (in_vld),
        .in_except     (in_except),
        .in_iq_choose  (in_iq_choose),
        .in_src1_en    (in_src1_en),
        .in_src2_en    (in_src2_en),
        .in_src1_pr    (in_src1_pr),
        .in_src2_pr    (in_src2_pr),
        .wr_pause      (wr_pause),
        .disp_fire     (disp_fire),
        .rob_id        (rob_id),
        .rob_wr_en     (rob_wr_en),
        .iq_choose     (iq_choose),
        .src1_rdy      (src1_rdy),
        .src2_rdy      (src2_rdy),
        .wr_rob_num    (wr_rob_num),
        .rob_room      (rob_room)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PTR_W-1:0] id(input int i);
        return rob_id[PTR_W*i +: PTR_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_vld       = '0;
        in_except    = '0;
        in_iq_choose = '0;
        in_src1_en   = '0;
        in_src2_en   = '0;
        in_src1_pr   = '0;
        in_src2_pr   = '0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pause", 32'(wr_pause), 0);
        chk("rst_fire", 32'(disp_fire), 0);
        chk("rst_wren", 32'(rob_wr_en), 0);
        chk("rst_iq", 32'(iq_choose), 0);
        chk("rst_num", 32'(wr_rob_num), 0);
        chk("rst_room", 32'(rob_room), 64);
        chk("rst_id", 32'(rob_id), 0);
        chk("rst_s1", 32'(src1_rdy), 4'b1111);
        chk("rst_s2", 32'(src2_rdy), 4'b1111);
        #9 rst_n = 1'b1;

        // full group from ptr 0
        in_vld = 4'b1111;
        in_iq_choose = 16'h8421;
        tick();
        clear_in();
        chk("g1_fire", 32'(disp_fire), 1);
        chk("g1_id0", 32'(id(0)), 0);
        chk("g1_id1", 32'(id(1)), 1);
        chk("g1_id2", 32'(id(2)), 2);
        chk("g1_id3", 32'(id(3)), 3);
        chk("g1_num", 32'(wr_rob_num), 4);
        chk("g1_iq", 32'(iq_choose), 16'h8421);
        tick();
        chk("g1_room", 32'(rob_room), 60);
        chk("g1_idle", 32'(disp_fire), 0);

        // wrap of the index: ptr 62, lanes 1 and 3
        flush = 1'b1;
        flush_rob_ptr = 7'd62;
        tick();
        flush = 1'b0;
        #1;
        chk("fl62_room", 32'(rob_room), 64);
        in_vld = 4'b1010;
        in_iq_choose = 16'h1010;
        tick();
        clear_in();
        chk("w_wren", 32'(rob_wr_en), 4'b1010);
        chk("w_num", 32'(wr_rob_num), 2);
        chk("w_id1", 32'(id(1)), 62);
        chk("w_id3", 32'(id(3)), 63);
        chk("w_iq", 32'(iq_choose), 16'h1010);
        tick();
        chk("w_room", 32'(rob_room), 62);

        // exception on lane 1 trims lanes 2 and 3; ptr now 1_000000
        in_vld = 4'b1111;
        in_except = 12'h010;
        in_iq_choose = 16'h8421;
        tick();
        clear_in();
        chk("x_wren", 32'(rob_wr_en), 4'b0011);
        chk("x_num", 32'(wr_rob_num), 2);
        chk("x_iq", 32'(iq_choose), 16'h0001);
        chk("x_id0", 32'(id(0)), 7'b1000000);
        chk("x_id1", 32'(id(1)), 7'b1000001);
        chk("x_fire", 32'(disp_fire), 1);
        tick();
        chk("x_room", 32'(rob_room), 60);

        // pause on an unused IQ does not stall
        in_vld = 4'b0011;
        in_iq_choose = 16'h0021;
        in_src1_en = 4'b0001;
        in_src1_pr = 28'd10;
        iq_pause = 4'b0100;
        #1;
        tick();
        chk("p0_pause", 32'(wr_pause), 0);
        chk("p0_fire", 32'(disp_fire), 1);
        chk("p0_id0", 32'(id(0)), 66);
        // same group reloads, then pause on a used IQ holds it
        tick();
        iq_pause = 4'b0001;
        clear_in();
        chk("p1_pause", 32'(wr_pause), 1);
        chk("p1_fire", 32'(disp_fire), 0);
        chk("p1_id0", 32'(id(0)), 68);
        chk("p1_s1", 32'(src1_rdy), 4'b1110);
        tick();
        chk("p2_pause", 32'(wr_pause), 1);
        chk("p2_id0", 32'(id(0)), 68);
        chk("p2_room", 32'(rob_room), 58);
        PR_wakeup[10] = 1'b1;
        #1;
        chk("p2_wake", 32'(src1_rdy), 4'b1111);
        tick();
        PR_wakeup[10] = 1'b0;
        #1;
        chk("p3_pause", 32'(wr_pause), 1);
        chk("p3_id1", 32'(id(1)), 69);
        chk("p3_s1", 32'(src1_rdy), 4'b1110);
        iq_pause = 4'b0000;
        #1;
        chk("p3_fire", 32'(disp_fire), 1);
        tick();

        // fill ROB to 62 (ptr 70 -> 124, occ 8 -> 62)
        in_vld = 4'b1111;
        in_iq_choose = 16'h1111;
        repeat (13) tick();
        in_vld = 4'b0011;
        in_iq_choose = 16'h0011;
        tick();
        clear_in();
        tick();
        chk("f_room62", 32'(rob_room), 2);

        // group of 4 with room 2 stalls; commit of 2 frees it next cycle
        in_vld = 4'b1111;
        in_iq_choose = 16'h1111;
        tick();
        clear_in();
        commit_num = 3'd2;
        #1;
        chk("c_pause", 32'(wr_pause), 1);
        chk("c_fire0", 32'(disp_fire), 0);
        chk("c_room2", 32'(rob_room), 2);
        tick();
        commit_num = 3'd0;
        #1;
        chk("c_room4", 32'(rob_room), 4);
        chk("c_fire1", 32'(disp_fire), 1);
        chk("c_id0", 32'(id(0)), 124);
        chk("c_id3", 32'(id(3)), 127);
        tick();
        chk("c_room0", 32'(rob_room), 0);
        chk("c_empty", 32'(wr_pause), 0);

        // full ROB: single-lane group stalls, then flush while paused
        in_vld = 4'b0001;
        in_iq_choose = 16'h0001;
        tick();
        clear_in();
        chk("full_pause", 32'(wr_pause), 1);
        flush = 1'b1;
        flush_rob_ptr = 7'b1000101;
        #1;
        chk("fl_fire", 32'(disp_fire), 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_room", 32'(rob_room), 64);
        chk("fl_wren", 32'(rob_wr_en), 0);
        chk("fl_pause", 32'(wr_pause), 0);
        in_vld = 4'b0001;
        in_iq_choose = 16'h0001;
        tick();
        clear_in();
        chk("fl_id0", 32'(id(0)), 7'b1000101);
        chk("fl_fire1", 32'(disp_fire), 1);
        chk("fl_num", 32'(wr_rob_num), 1);
        tick();
        chk("fl_room63", 32'(rob_room), 63);
        commit_num = 3'd1;
        tick();
        commit_num = 3'd0;
        #1;
        chk("cm_room64", 32'(rob_room), 64);

        // full wrap of the pointer and out-of-range source register
        flush = 1'b1;
        flush_rob_ptr = 7'd126;
        tick();
        flush = 1'b0;
        in_vld = 4'b1111;
        in_iq_choose = 16'h1111;
        in_src2_en = 4'b0011;
        in_src2_pr = {7'd0, 7'd0, 7'd64, 7'd100};
        #1;
        tick();
        clear_in();
        chk("wr_id0", 32'(id(0)), 126);
        chk("wr_id1", 32'(id(1)), 127);
        chk("wr_id2", 32'(id(2)), 0);
        chk("wr_id3", 32'(id(3)), 1);
        chk("wr_s2", 32'(src2_rdy), 4'b1101);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
